// File: rtl/ysyx_23060025_axi_burst_rom_if.sv
// AXI4 read-only channel bundle (AR + R) between a burst initiator and the burst ROM.
// The master drives the request and rready; the slave drives arready and the beat fields.
interface ysyx_23060025_axi_burst_rom_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] in_araddr;
  logic                  in_arvalid;
  logic                  in_arready;
  logic [7:0]            in_arlen;
  logic [2:0]            in_arsize;
  logic [1:0]            in_arburst;
  logic                  in_rvalid;
  logic                  in_rready;
  logic [DATA_WIDTH-1:0] in_rdata;
  logic [1:0]            in_rresp;
  logic                  in_rlast;

  modport master (
    output in_araddr, in_arvalid, in_arlen, in_arsize, in_arburst, in_rready,
    input  in_arready, in_rvalid, in_rdata, in_rresp, in_rlast
  );

  modport slave (
    input  in_araddr, in_arvalid, in_arlen, in_arsize, in_arburst, in_rready,
    output in_arready, in_rvalid, in_rdata, in_rresp, in_rlast
  );
endinterface

// File: rtl/ysyx_23060025_axi_burst_rom.sv
// AXI4 read-burst responder over a preloadable word array: one burst at a time,
// programmable first-beat latency, registered R beats held under rready back-pressure.
module ysyx_23060025_axi_burst_rom #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH_W  = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  ysyx_23060025_axi_burst_rom_if.slave bus,
  input  logic                   load_en,
  input  logic [MEM_DEPTH_W-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]  load_data
);
  localparam int DEPTH = 1 << MEM_DEPTH_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [3:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic                  accept;
  logic                  err_in;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  ld;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [7:0]            ld_cnt;
  logic [7:0]            ld_len;
  logic                  ld_err;
  logic                  unused_addr_bits;

  assign bus.in_arready = (state == S_IDLE) && !reset;
  assign bus.in_rvalid  = (state == S_BURST);
  assign bus.in_rdata   = rdata_q;
  assign bus.in_rresp   = rresp_q;
  assign bus.in_rlast   = rlast_q;

  assign accept    = bus.in_arvalid && bus.in_arready;
  // Only 4-byte INCR/FIXED bursts are served; everything else answers SLVERR.
  assign err_in    = (bus.in_arsize != 3'd2) || bus.in_arburst[1];
  assign next_addr = (burst_q == 2'b01) ? addr_q + ADDR_WIDTH'(4) : addr_q;

  // Word index drops the byte offset and everything above the array depth.
  assign unused_addr_bits = ^{ld_addr[ADDR_WIDTH-1:MEM_DEPTH_W+2], ld_addr[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // ld marks an edge that loads a beat into the R registers; ld_* describe that beat.
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_addr = addr_q;
    ld_cnt  = beat_cnt + 8'd1;
    ld_len  = len_q;
    ld_err  = err_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (READ_LATENCY == 0) begin
            state_n = S_BURST;
            ld      = 1'b1;
            ld_addr = bus.in_araddr;
            ld_cnt  = 8'd0;
            ld_len  = bus.in_arlen;
            ld_err  = err_in;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt <= 4'd1) begin
          state_n = S_BURST;
          ld      = 1'b1;
          ld_cnt  = 8'd0;
        end
      end
      S_BURST: begin
        if (bus.in_rready) begin
          if (rlast_q) begin
            state_n = S_IDLE;
          end else begin
            ld      = 1'b1;
            ld_addr = next_addr;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      lat_cnt  <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= bus.in_araddr;
        len_q    <= bus.in_arlen;
        burst_q  <= bus.in_arburst;
        err_q    <= err_in;
        beat_cnt <= '0;
        lat_cnt  <= 4'(READ_LATENCY);
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      // A same-edge preload of this word is not visible here: the beat takes the old value.
      if (ld) begin
        addr_q   <= ld_addr;
        beat_cnt <= ld_cnt;
        rdata_q  <= ld_err ? '0 : mem[ld_addr[MEM_DEPTH_W+1:2]];
        rresp_q  <= ld_err ? 2'b10 : 2'b00;
        rlast_q  <= (ld_cnt == ld_len);
      end
    end
  end

  // Array keeps its contents through reset.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end
endmodule
